// File: rtl/muxn_scan.sv
// rtl/muxn_scan.sv - registered N-channel multiplexer with manual select and auto-scan
//
// Purpose:
//   Picks one WIDTH-bit channel out of NUM_CH and registers it for a single
//   downstream consumer. Two modes of operation:
//     manual (mode=0)    : the channel is chosen by sel.
//     auto-scan (mode=1) : an internal channel counter walks the channels,
//                          spending DWELL cycles on each one.
//
// Optional feature (macro MUXN_SCAN_MASK_EN):
//   Adds the ch_mask input. Masked channels are skipped during the scan and
//   are reported as not valid in manual mode. When the macro is not defined,
//   the port does not exist and every channel is enabled.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   in_bus   in   NUM_CH*WIDTH bits; channel k is in_bus[k*WIDTH +: WIDTH]
//   sel      in   SEL_W-bit manual channel select
//   mode     in   0 = manual, 1 = auto-scan
//   hold     in   auto-scan only: freezes the dwell and channel counters
//   ch_mask  in   NUM_CH bits, bit k enables channel k (only with the macro)
//   out      out  registered data of the selected channel
//   out_ch   out  index of the channel that out was taken from
//   out_vld  out  out/out_ch describe a legal, enabled channel
//   wrap     out  one-cycle pulse when the scan passes channel NUM_CH-1

module muxn_scan #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 1,
    parameter int DWELL  = 4,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    hold,
`ifdef MUXN_SCAN_MASK_EN
    input  logic [NUM_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]        out,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_vld,
    output logic                    wrap
);

    // One extra bit so the dwell counter can never overflow before its limit.
    localparam int DW_W = $clog2(DWELL) + 1;

    typedef enum logic {
        S_MAN  = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   ch_q;
    logic [SEL_W-1:0]   ch_d;
    logic [DW_W-1:0]    dwell_q;
    logic [DW_W-1:0]    dwell_d;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   out_d;
    logic [SEL_W-1:0]   out_ch_q;
    logic [SEL_W-1:0]   out_ch_d;
    logic               out_vld_q;
    logic               out_vld_d;
    logic               wrap_q;
    logic               wrap_d;

    // Channel enables; all ones unless the mask feature is built in.
    logic [NUM_CH-1:0]  en_mask;

`ifdef MUXN_SCAN_MASK_EN
    assign en_mask = ch_mask;
`else
    assign en_mask = '1;
`endif

    // ------------------------------------------------------------------
    // Channel search helpers
    // ------------------------------------------------------------------

    // Lowest enabled channel: the starting point when a scan begins.
    logic [SEL_W-1:0]   first_ch;
    logic               any_en;

    always_comb begin
        first_ch = '0;
        any_en   = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (en_mask[k]) begin
                first_ch = SEL_W'(k);
                any_en   = 1'b1;
            end
        end
    end

    // Next enabled channel after ch_q, searched circularly. The search runs
    // up to NUM_CH steps so a single enabled channel finds itself again;
    // stepping past index NUM_CH-1 on the way is what raises wrap.
    logic [SEL_W-1:0]   next_ch;
    logic               next_wrap;
    logic               next_found;

    always_comb begin
        next_ch    = ch_q;
        next_wrap  = 1'b0;
        next_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!next_found && en_mask[(int'(ch_q) + i) % NUM_CH]) begin
                next_found = 1'b1;
                next_ch    = SEL_W'((int'(ch_q) + i) % NUM_CH);
                next_wrap  = (int'(ch_q) + i >= NUM_CH);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_MAN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state simply follows mode every clock
    // ------------------------------------------------------------------
    always_comb begin
        state_d = mode ? S_SCAN : S_MAN;
    end

    // ------------------------------------------------------------------
    // FSM: outputs and counters
    //
    // The selection rule is that of state_d, so the cycle on which the mode
    // changes already behaves like the new state. The registered outputs
    // report ch_d (the channel after this edge's advance), which lines wrap
    // up with the first cycle that shows the restarted channel.
    // ------------------------------------------------------------------
    always_comb begin
        ch_d      = ch_q;
        dwell_d   = dwell_q;
        out_d     = '0;
        out_ch_d  = '0;
        out_vld_d = 1'b0;
        wrap_d    = 1'b0;

        if (state_d == S_MAN) begin
            ch_d     = '0;
            dwell_d  = '0;
            out_ch_d = sel;
            // sel can exceed NUM_CH-1 when NUM_CH is not a power of two.
            if (int'(sel) < NUM_CH) begin
                if (en_mask[sel]) begin
                    out_d     = in_bus[int'(sel)*WIDTH +: WIDTH];
                    out_vld_d = 1'b1;
                end
            end
        end else begin
            if (state_q == S_MAN) begin
                // Scan entry: start at the first enabled channel, fresh dwell.
                ch_d    = first_ch;
                dwell_d = '0;
            end else if (!hold && any_en) begin
                if (dwell_q == DW_W'(DWELL - 1)) begin
                    dwell_d = '0;
                    ch_d    = next_ch;
                    wrap_d  = next_wrap;
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end

            // Data is live: it follows in_bus even while the counters hold.
            out_ch_d = ch_d;
            if (any_en && en_mask[ch_d]) begin
                out_d     = in_bus[int'(ch_d)*WIDTH +: WIDTH];
                out_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q      <= '0;
            dwell_q   <= '0;
            out_q     <= '0;
            out_ch_q  <= '0;
            out_vld_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            ch_q      <= ch_d;
            dwell_q   <= dwell_d;
            out_q     <= out_d;
            out_ch_q  <= out_ch_d;
            out_vld_q <= out_vld_d;
            wrap_q    <= wrap_d;
        end
    end

    assign out     = out_q;
    assign out_ch  = out_ch_q;
    assign out_vld = out_vld_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_muxn_scan.sv
// tb/tb_muxn_scan.sv - directed self-checking bench for muxn_scan

module tb_muxn_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_bus;
    logic [1:0]  sel;
    logic        mode;
    logic        hold;
`ifdef MUXN_SCAN_MASK_EN
    logic [3:0]  ch_mask_a;
    logic [3:0]  ch_mask_b;
    logic [2:0]  ch_mask_c;
`endif

    logic [7:0]  out_a, out_b, out_c;
    logic [1:0]  ch_a, ch_b, ch_c;
    logic        vld_a, vld_b, vld_c;
    logic        wrap_a, wrap_b, wrap_c;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Main instance: 4 channels, 8 bits, dwell 2.
    muxn_scan #(.NUM_CH(4), .WIDTH(8), .DWELL(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel),
        .mode(mode), .hold(hold),
`ifdef MUXN_SCAN_MASK_EN
        .ch_mask(ch_mask_a),
`endif
        .out(out_a), .out_ch(ch_a), .out_vld(vld_a), .wrap(wrap_a)
    );

    // Dwell of one cycle.
    muxn_scan #(.NUM_CH(4), .WIDTH(8), .DWELL(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel),
        .mode(mode), .hold(hold),
`ifdef MUXN_SCAN_MASK_EN
        .ch_mask(ch_mask_b),
`endif
        .out(out_b), .out_ch(ch_b), .out_vld(vld_b), .wrap(wrap_b)
    );

    // Non power-of-two channel count.
    muxn_scan #(.NUM_CH(3), .WIDTH(8), .DWELL(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus[23:0]), .sel(sel),
        .mode(mode), .hold(hold),
`ifdef MUXN_SCAN_MASK_EN
        .ch_mask(ch_mask_c),
`endif
        .out(out_c), .out_ch(ch_c), .out_vld(vld_c), .wrap(wrap_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        mode   = 1'b0;
        hold   = 1'b0;
        sel    = 2'd0;
        in_bus = 32'h44332211;
        tick();
        tick();
        total++; if (out_a !== 8'h00) $display("FAIL reset_out: got %h want 00", out_a); else passed++;
        total++; if (ch_a !== 2'd0) $display("FAIL reset_out_ch: got %0d want 0", ch_a); else passed++;
        total++; if (vld_a !== 1'b0) $display("FAIL reset_vld: got %b want 0", vld_a); else passed++;
        total++; if (wrap_a !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap_a); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (out_a !== 8'h11) $display("FAIL first_out: got %h want 11", out_a); else passed++;
        total++; if (ch_a !== 2'd0) $display("FAIL first_out_ch: got %0d want 0", ch_a); else passed++;
        total++; if (vld_a !== 1'b1) $display("FAIL first_vld: got %b want 1", vld_a); else passed++;
    endtask

    task automatic test_manual;
        logic [7:0] exp_m [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            if (s > 0) begin
                total++;
                if (out_a !== exp_m[s-1]) $display("FAIL man_latency[%0d]: got %h want %h", s, out_a, exp_m[s-1]); else passed++;
            end
            tick();
            total++; if (out_a !== exp_m[s]) $display("FAIL man_out[%0d]: got %h want %h", s, out_a, exp_m[s]); else passed++;
            total++; if (ch_a !== 2'(s)) $display("FAIL man_ch[%0d]: got %0d want %0d", s, ch_a, s); else passed++;
            total++; if (wrap_a !== 1'b0) $display("FAIL man_wrap[%0d]: got %b want 0", s, wrap_a); else passed++;
        end
    endtask

    task automatic test_auto;
        logic [7:0] exp_m [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        int         exp_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int         exp_wr [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (ch_a !== 2'(exp_ch[i])) $display("FAIL auto_ch[%0d]: got %0d want %0d", i, ch_a, exp_ch[i]); else passed++;
            total++; if (wrap_a !== 1'(exp_wr[i])) $display("FAIL auto_wrap[%0d]: got %b want %0d", i, wrap_a, exp_wr[i]); else passed++;
            total++; if (out_a !== exp_m[exp_ch[i]]) $display("FAIL auto_out[%0d]: got %h want %h", i, out_a, exp_m[exp_ch[i]]); else passed++;
        end
    endtask

    task automatic test_hold;
        tick();
        total++; if (ch_a !== 2'd1) $display("FAIL hold_pre_ch: got %0d want 1", ch_a); else passed++;
        hold = 1'b1;
        for (int h = 0; h < 5; h++) begin
            tick();
            total++; if (ch_a !== 2'd1) $display("FAIL hold_ch[%0d]: got %0d want 1", h, ch_a); else passed++;
            total++; if (wrap_a !== 1'b0) $display("FAIL hold_wrap[%0d]: got %b want 0", h, wrap_a); else passed++;
            total++;
            if (out_a !== ((h < 2) ? 8'h22 : 8'hAA)) $display("FAIL hold_out[%0d]: got %h want %h", h, out_a, (h < 2) ? 8'h22 : 8'hAA); else passed++;
            if (h == 1) in_bus = 32'h4433AA11;
        end
        hold = 1'b0;
        tick();
        total++; if (ch_a !== 2'd1) $display("FAIL hold_resume_ch: got %0d want 1", ch_a); else passed++;
        total++; if (out_a !== 8'hAA) $display("FAIL hold_resume_out: got %h want aa", out_a); else passed++;
        in_bus = 32'h44332211;
        tick();
        total++; if (ch_a !== 2'd2) $display("FAIL hold_next_ch: got %0d want 2", ch_a); else passed++;
        total++; if (out_a !== 8'h33) $display("FAIL hold_next_out: got %h want 33", out_a); else passed++;
    endtask

    task automatic test_async_reset;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_a !== 8'h00) $display("FAIL areset_out: got %h want 00", out_a); else passed++;
        total++; if (ch_a !== 2'd0) $display("FAIL areset_ch: got %0d want 0", ch_a); else passed++;
        total++; if (vld_a !== 1'b0) $display("FAIL areset_vld: got %b want 0", vld_a); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (ch_a !== 2'd0) $display("FAIL restart_ch0: got %0d want 0", ch_a); else passed++;
        total++; if (out_a !== 8'h11) $display("FAIL restart_out0: got %h want 11", out_a); else passed++;
        total++; if (vld_a !== 1'b1) $display("FAIL restart_vld: got %b want 1", vld_a); else passed++;
        tick();
        total++; if (ch_a !== 2'd0) $display("FAIL restart_ch1: got %0d want 0", ch_a); else passed++;
        tick();
        total++; if (ch_a !== 2'd1) $display("FAIL restart_ch2: got %0d want 1", ch_a); else passed++;
    endtask

    task automatic test_hold_mode;
        hold = 1'b1;
        mode = 1'b0;
        sel  = 2'd2;
        tick();
        total++; if (ch_a !== 2'd2) $display("FAIL hm_ch: got %0d want 2", ch_a); else passed++;
        total++; if (out_a !== 8'h33) $display("FAIL hm_out: got %h want 33", out_a); else passed++;
        total++; if (vld_a !== 1'b1) $display("FAIL hm_vld: got %b want 1", vld_a); else passed++;
        hold = 1'b0;
        mode = 1'b1;
        tick();
        total++; if (ch_a !== 2'd0) $display("FAIL hm_reentry_ch0: got %0d want 0", ch_a); else passed++;
        tick();
        total++; if (ch_a !== 2'd0) $display("FAIL hm_reentry_ch1: got %0d want 0", ch_a); else passed++;
        tick();
        total++; if (ch_a !== 2'd1) $display("FAIL hm_reentry_ch2: got %0d want 1", ch_a); else passed++;
    endtask

    task automatic test_dwell1;
        int exp_ch [6] = '{0, 1, 2, 3, 0, 1};
        int exp_wr [6] = '{0, 0, 0, 0, 1, 0};
        mode = 1'b0;
        tick();
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (ch_b !== 2'(exp_ch[i])) $display("FAIL d1_ch[%0d]: got %0d want %0d", i, ch_b, exp_ch[i]); else passed++;
            total++; if (wrap_b !== 1'(exp_wr[i])) $display("FAIL d1_wrap[%0d]: got %b want %0d", i, wrap_b, exp_wr[i]); else passed++;
            total++; if (out_b !== 8'(8'h11 * (exp_ch[i] + 1))) $display("FAIL d1_out[%0d]: got %h want %h", i, out_b, 8'(8'h11 * (exp_ch[i] + 1))); else passed++;
        end
    endtask

    task automatic test_nonpow2;
        int exp_ch [4] = '{0, 1, 2, 0};
        int exp_wr [4] = '{0, 0, 0, 1};
        mode = 1'b0;
        sel  = 2'd3;
        tick();
        total++; if (ch_c !== 2'd3) $display("FAIL np2_bad_ch: got %0d want 3", ch_c); else passed++;
        total++; if (vld_c !== 1'b0) $display("FAIL np2_bad_vld: got %b want 0", vld_c); else passed++;
        total++; if (out_c !== 8'h00) $display("FAIL np2_bad_out: got %h want 00", out_c); else passed++;
        sel = 2'd2;
        tick();
        total++; if (out_c !== 8'h33) $display("FAIL np2_sel2_out: got %h want 33", out_c); else passed++;
        total++; if (vld_c !== 1'b1) $display("FAIL np2_sel2_vld: got %b want 1", vld_c); else passed++;
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ch_c !== 2'(exp_ch[i])) $display("FAIL np2_ch[%0d]: got %0d want %0d", i, ch_c, exp_ch[i]); else passed++;
            total++; if (wrap_c !== 1'(exp_wr[i])) $display("FAIL np2_wrap[%0d]: got %b want %0d", i, wrap_c, exp_wr[i]); else passed++;
        end
    endtask

`ifdef MUXN_SCAN_MASK_EN
    task automatic test_mask;
        int exp_ch [4] = '{1, 3, 1, 3};
        int exp_wr [4] = '{0, 0, 1, 0};
        ch_mask_b = 4'b1010;
        mode      = 1'b0;
        sel       = 2'd0;
        tick();
        total++; if (vld_b !== 1'b0) $display("FAIL mask_man_vld: got %b want 0", vld_b); else passed++;
        total++; if (out_b !== 8'h00) $display("FAIL mask_man_out: got %h want 00", out_b); else passed++;
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ch_b !== 2'(exp_ch[i])) $display("FAIL mask_ch[%0d]: got %0d want %0d", i, ch_b, exp_ch[i]); else passed++;
            total++; if (wrap_b !== 1'(exp_wr[i])) $display("FAIL mask_wrap[%0d]: got %b want %0d", i, wrap_b, exp_wr[i]); else passed++;
        end
        ch_mask_b = 4'b0000;
        tick();
        total++; if (vld_b !== 1'b0) $display("FAIL mask_zero_vld: got %b want 0", vld_b); else passed++;
        total++; if (out_b !== 8'h00) $display("FAIL mask_zero_out: got %h want 00", out_b); else passed++;
        ch_mask_b = 4'hF;
    endtask
`endif

    initial begin
`ifdef MUXN_SCAN_MASK_EN
        ch_mask_a = 4'hF;
        ch_mask_b = 4'hF;
        ch_mask_c = 3'h7;
`endif
        test_reset();
        test_manual();
        test_auto();
        test_hold();
        test_async_reset();
        test_hold_mode();
        test_dwell1();
        test_nonpow2();
`ifdef MUXN_SCAN_MASK_EN
        test_mask();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
